// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg
//   Shared constants and types for the slide-switch debouncer.
//   - CLK_HZ / DEBOUNCE_MS give the default debounce time in clock cycles.
//   - clog2() sizes the per-bit stability counter from the cycle count.
//   - db_state_e is the per-bit two-state debounce FSM encoding.
package switch_debouncer_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms at 50 MHz -> 500000 cycles.
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int CNT_W_DEF = clog2(DEBOUNCE_CYCLES_DEF);

  typedef enum logic {
    ST_STABLE   = 1'b0,  // synchronised input agrees with the debounced level
    ST_COUNTING = 1'b1   // disagreement seen, counting consecutive cycles
  } db_state_e;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// debounce_bit
//   Single-bit switch conditioner: two-flop synchroniser, stability counter,
//   two-state FSM and registered rise/fall pulses.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   sw_raw_i  - raw switch level, asynchronous to clk
//   db_o      - debounced level
//   rise_o    - one-cycle pulse when db_o goes 0->1
//   fall_o    - one-cycle pulse when db_o goes 1->0
//   flip_o    - combinational: db_o will toggle on the coming edge
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic flip_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  db_state_e        state_q;
  logic             mismatch;

  assign mismatch = s2_q ^ db_q;

  // The final mismatching cycle of a full run: accept the new level now.
  assign flip_o = (state_q == ST_COUNTING) && mismatch && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_STABLE;
    end else begin
      s1_q   <= sw_raw_i;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (mismatch) begin
            // First disagreeing cycle counts as one.
            cnt_q   <= CNT_W'(1);
            state_q <= ST_COUNTING;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_COUNTING: begin
          if (!mismatch) begin
            // Any agreement discards the whole run.
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            db_q    <= s2_q;
            rise_q  <= s2_q;
            fall_q  <= ~s2_q;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_STABLE;
        end
      endcase
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Debounces WIDTH raw slide switches and produces edge pulses plus a
//   sticky change flag.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-high reset
//   sw_raw      - raw switch levels, asynchronous to clk
//   clr_changed - synchronous clear of sw_changed
//   sw_db       - debounced switch levels
//   sw_rise     - one-cycle pulses on sw_db 0->1
//   sw_fall     - one-cycle pulses on sw_db 1->0
//   sw_changed  - sticky flag, set whenever any sw_db bit flips
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clr_changed,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] flip;
  logic             sw_changed_q;
  logic             sw_changed_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .sw_raw_i(sw_raw[gi]),
      .db_o    (sw_db[gi]),
      .rise_o  (sw_rise[gi]),
      .fall_o  (sw_fall[gi]),
      .flip_o  (flip[gi])
    );
  end

  // A flip on the same edge as a clear keeps the flag set.
  always_comb begin
    sw_changed_d = sw_changed_q;
    if (clr_changed) sw_changed_d = 1'b0;
    if (|flip)       sw_changed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sw_changed_q <= 1'b0;
    else       sw_changed_q <= sw_changed_d;
  end

  assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic         clr_changed;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int passed;
  int total;

  switch_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .clr_changed(clr_changed),
    .sw_db      (sw_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: keep the raw samples taken at each edge. The level seen
  // after the two-flop synchroniser at edge n is the raw sample of edge n-2,
  // so a bit flips at edge n when the raw samples of edges n-D-1 .. n-2 all
  // differ from the current debounced level. hist[k] = raw sample of edge n-1-k.
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_db, m_rise, m_fall, m_flip;
  logic         m_changed;

  always_comb begin
    m_flip = '1;
    for (int k = 1; k <= D; k++) m_flip = m_flip & (hist[k] ^ m_db);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= D; k++) hist[k] <= '0;
      m_db      <= '0;
      m_rise    <= '0;
      m_fall    <= '0;
      m_changed <= 1'b0;
    end else begin
      hist[0] <= sw_raw;
      for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
      m_db   <= m_db ^ m_flip;
      m_rise <= m_flip & ~m_db;
      m_fall <= m_flip & m_db;
      if (|m_flip)          m_changed <= 1'b1;
      else if (clr_changed) m_changed <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_db",      sw_db,   m_db);
    chk("model_rise",    sw_rise, m_rise);
    chk("model_fall",    sw_fall, m_fall);
    chk("model_changed", {7'b0, sw_changed}, {7'b0, m_changed});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    passed      = 0;
    total       = 0;
    reset       = 1'b1;
    sw_raw      = '0;
    clr_changed = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("rst_db",      sw_db,   8'h00);
    chk("rst_rise",    sw_rise, 8'h00);
    chk("rst_changed", {7'b0, sw_changed}, 8'h00);

    // Single bit rises exactly 6 edges after the raw change.
    sw_raw = 8'h01;
    tick(5);
    chk("t2_db_early", sw_db, 8'h00);
    tick(1);
    chk("t2_db",   sw_db,   8'h01);
    chk("t2_rise", sw_rise, 8'h01);
    chk("t2_fall", sw_fall, 8'h00);
    tick(1);
    chk("t2_rise_gone", sw_rise, 8'h00);
    chk("t2_changed",   {7'b0, sw_changed}, 8'h01);
    clr_changed = 1'b1;
    tick(1);
    clr_changed = 1'b0;
    chk("t2_cleared", {7'b0, sw_changed}, 8'h00);

    // Short glitches on bit 3 are discarded.
    repeat (10) begin
      sw_raw[3] = 1'b1;
      tick(3);
      sw_raw[3] = 1'b0;
      tick(3);
    end
    chk("t3_db",      sw_db, 8'h01);
    chk("t3_changed", {7'b0, sw_changed}, 8'h00);

    // Multi-bit change 00 -> A5 -> 00.
    sw_raw = 8'h00;
    tick(8);
    clr_changed = 1'b1;
    tick(1);
    clr_changed = 1'b0;
    chk("t4_db_zero", sw_db, 8'h00);
    sw_raw = 8'hA5;
    tick(5);
    chk("t4_db_early", sw_db, 8'h00);
    tick(1);
    chk("t4_db",   sw_db,   8'hA5);
    chk("t4_rise", sw_rise, 8'hA5);
    tick(1);
    chk("t4_rise_gone", sw_rise, 8'h00);
    sw_raw = 8'h00;
    tick(6);
    chk("t4_fall", sw_fall, 8'hA5);
    chk("t4_db0",  sw_db,   8'h00);
    tick(1);
    chk("t4_fall_gone", sw_fall, 8'h00);

    // Clear on the flip edge loses to the flip; a later clear wins.
    clr_changed = 1'b1;
    tick(1);
    clr_changed = 1'b0;
    sw_raw = 8'h10;
    tick(5);
    clr_changed = 1'b1;
    tick(1);
    chk("t5_db",         sw_db, 8'h10);
    chk("t5_set_wins",   {7'b0, sw_changed}, 8'h01);
    tick(1);
    clr_changed = 1'b0;
    chk("t5_cleared",    {7'b0, sw_changed}, 8'h00);

    // Bit 1: three mismatching cycles, one-cycle glitch, then hold.
    sw_raw = 8'h12;
    tick(3);
    sw_raw = 8'h10;
    tick(1);
    sw_raw = 8'h12;
    tick(2);
    chk("t6_no_early", sw_db, 8'h10);
    tick(3);
    chk("t6_edge9", sw_db, 8'h10);
    tick(1);
    chk("t6_db",   sw_db,   8'h12);
    chk("t6_rise", sw_rise, 8'h02);

    // Mid-simulation asynchronous reset while counting with switches high.
    sw_raw = 8'hFF;
    tick(2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_db",      sw_db,   8'h00);
    chk("t1_async_rise",    sw_rise, 8'h00);
    chk("t1_async_fall",    sw_fall, 8'h00);
    chk("t1_async_changed", {7'b0, sw_changed}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    chk("t1_db_early", sw_db, 8'h00);
    tick(1);
    chk("t1_db",      sw_db,   8'hFF);
    chk("t1_rise",    sw_rise, 8'hFF);
    chk("t1_changed", {7'b0, sw_changed}, 8'h01);
    tick(1);
    chk("t1_rise_gone", sw_rise, 8'h00);

    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
